slave_port: RTL and testbench
=============================

# slave_port

Responder end of the serial system bus. Each slave instance sits behind the master-side routing and receives one master's bit-serial request stream. It deserialises the address and write data, performs single-cycle accesses on a local synchronous memory port, and serialises read data back toward the granted master, supporting incrementing bursts.

## Interface

**Parameters**
- ADDR_WIDTH, 12, address bits shifted in per transaction; local address width.
- DATA_WIDTH, 8, data bits per word, both directions.

**Ports**
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- master_valid  in  1  master presents a valid request bit this cycle.
- master_ready  in  1  master accepts the current rx_data bit this cycle.
- read_en  in  1  read request; sampled at transaction start only.
- write_en  in  1  write request; sampled at transaction start only.
- tx_address  in  1  serial address bit, MSB first.
- tx_data  in  1  serial write data bit, MSB first.
- tx_burst  in  1  continue-burst flag, sampled at the end of each word.
- slave_ready  out  1  slave accepts the request bit this cycle.
- slave_valid  out  1  rx_data carries a valid read bit.
- rx_data  out  1  serial read data, MSB first.
- mem_addr  out  ADDR_WIDTH  local memory address.
- mem_wdata  out  DATA_WIDTH  local write data.
- mem_we  out  1  single-cycle write strobe.
- mem_re  out  1  single-cycle read strobe; mem_rdata is valid the following cycle.
- mem_rdata  in  DATA_WIDTH  local read data.
- txn_done  out  1  one-cycle pulse on completion of each word, read or write.

## Operation

- Request bit accepted = master_valid & slave_ready. Read bit accepted = slave_valid & master_ready.
- slave_ready = 1 in IDLE, ADDR, and WDATA; 0 in all other states. slave_valid = 1 only in RDATA.

**States**
- IDLE: on an accepted bit with exactly one of read_en/write_en high, latch the opcode, shift in tx_address as address bit 0 of the count, and go to ADDR.
  - Both enables high, or neither: ignore; stay in IDLE.
  - If ADDR_WIDTH == 1, go directly to the next phase.
- ADDR: shift tx_address on each accepted bit. After ADDR_WIDTH bits total:
  - write goes to WDATA;
  - read goes to RMEM.
  - master_valid low stalls the state with no shift.
- WDATA: shift tx_data on each accepted bit. On the DATA_WIDTH-th bit, latch tx_burst into burst_flag and go to WRITE.
- WRITE: mem_we = 1 for one cycle with the current mem_addr/mem_wdata; txn_done = 1.
  - burst_flag = 1: mem_addr increments and the FSM returns to WDATA.
  - otherwise: go to IDLE.
- RMEM: mem_re = 1 for one cycle; go to RLOAD.
- RLOAD: load mem_rdata into the read shift register; go to RDATA.
- RDATA: rx_data = shift register MSB; shift on each accepted read bit. On the DATA_WIDTH-th accepted bit, sample tx_burst and pulse txn_done.
  - tx_burst = 1: mem_addr increments and the FSM goes to RMEM.
  - otherwise: go to IDLE.
- Address increment wraps modulo 2^ADDR_WIDTH: the address after all-ones is 0.
- read_en/write_en changes after the first address bit are ignored until the FSM returns to IDLE.

## Timing

- Reset values: state IDLE, slave_ready = 1, slave_valid = 0, rx_data = 0, mem_we = 0, mem_re = 0, txn_done = 0, mem_addr = 0, mem_wdata = 0, all counters and burst_flag = 0.
- Reset asserted mid-transaction aborts it immediately. No mem_we or mem_re is issued for the aborted word.
- Write latency: mem_we is high in the cycle immediately after the cycle that accepted the last data bit.
- Minimum single write: ADDR_WIDTH + DATA_WIDTH + 1 cycles.
- Read latency: mem_re is high in the cycle after the last address bit. slave_valid first rises 2 cycles after mem_re, i.e. in the third cycle after the last address bit.
- Read burst gap: 2 cycles with slave_valid = 0 (RMEM, RLOAD) between words.
- Write burst gap: 1 cycle with slave_ready = 0 (WRITE) between words.
- rx_data and slave_valid are held stable while master_ready = 0.
- mem_* outputs and txn_done are registered or decoded from registered state. No combinational path exists from inputs to slave_ready or slave_valid.

## Test plan

- **Single write:** write_en, address 0x0A5, data 0x3C, tx_burst = 0 → one mem_we pulse with mem_addr = 0x0A5 and mem_wdata = 0x3C; txn_done once; back to IDLE with slave_ready = 1.
- **Burst write with wrap:** address 0xFFF, words 0x11 then 0x22, tx_burst = 1 on the first word and 0 on the second → mem_we at 0xFFF/0x11, then at 0x000/0x22; slave_ready = 0 only during the WRITE cycles.
- **Read with backpressure:** read_en, address 0x010, mem_rdata = 0xA6 → slave_valid rises 3 cycles after the last address bit; rx_data sequence 1,0,1,0,0,1,1,0; master_ready held low for 2 cycles mid-word → rx_data held; txn_done once.
- **Request stall:** master_valid low for 3 cycles mid-address → no shift during the stall; the final address is still correct.
- **Illegal request:** read_en = write_en = 1 with master_valid = 1 → FSM stays IDLE; no mem_we or mem_re.
- **Reset abort:** rst asserted after 4 write data bits, then released → all outputs at reset values; no mem_we; the next clean write completes normally.

Source files
------------

// File: rtl/slave_port.sv
// slave_port: responder end of the serial system bus.
// Deserialises a bit-serial address/write-data request, performs single-cycle
// accesses on a local synchronous memory port and serialises read data back,
// with incrementing bursts in both directions.
module slave_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  master_valid,
  input  logic                  master_ready,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic                  tx_address,
  input  logic                  tx_data,
  input  logic                  tx_burst,
  output logic                  slave_ready,
  output logic                  slave_valid,
  output logic                  rx_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  txn_done
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_RMEM,
    S_RLOAD,
    S_RDATA
  } state_e;

  state_e                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rshift_q, rshift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  burst_q, burst_d;
  logic                  done_q, done_d;

  logic req_acc;
  logic rd_acc;

  // Handshake flags and memory-side outputs, all decoded from registered state.
  assign slave_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign slave_valid = (state_q == S_RDATA);
  assign rx_data     = slave_valid & rshift_q[DATA_WIDTH-1];
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = (state_q == S_WRITE);
  assign mem_re      = (state_q == S_RMEM);
  assign txn_done    = done_q;

  assign req_acc = master_valid & slave_ready;
  assign rd_acc  = slave_valid & master_ready;

  // Next-state, shift-register and counter logic.
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rshift_d = rshift_q;
    cnt_d    = cnt_q;
    burst_d  = burst_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_acc && (read_en ^ write_en)) begin
          is_wr_d   = write_en;
          addr_d    = '0;
          addr_d[0] = tx_address;
          if (ADDR_WIDTH == 1) begin
            cnt_d   = '0;
            state_d = write_en ? S_WDATA : S_RMEM;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        if (req_acc) begin
          addr_d    = addr_q << 1;
          addr_d[0] = tx_address;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = is_wr_q ? S_WDATA : S_RMEM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_WDATA: begin
        if (req_acc) begin
          wdata_d    = wdata_q << 1;
          wdata_d[0] = tx_data;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            burst_d = tx_burst;
            done_d  = 1'b1;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_WRITE: begin
        burst_d = 1'b0;
        if (burst_q) begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_WDATA;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RMEM: begin
        state_d = S_RLOAD;
      end

      S_RLOAD: begin
        rshift_d = mem_rdata;
        cnt_d    = '0;
        state_d  = S_RDATA;
      end

      S_RDATA: begin
        if (rd_acc) begin
          rshift_d = rshift_q << 1;
          if (cnt_q == DATA_LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
            if (tx_burst) begin
              addr_d  = addr_q + ADDR_ONE;
              state_d = S_RMEM;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rshift_q <= '0;
      cnt_q    <= '0;
      burst_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rshift_q <= rshift_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// tb_slave_port: directed bench for slave_port with hand-computed expectations.
module tb_slave_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        master_valid = 1'b0;
  logic        master_ready = 1'b0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic        tx_address = 1'b0;
  logic        tx_data = 1'b0;
  logic        tx_burst = 1'b0;
  logic        slave_ready;
  logic        slave_valid;
  logic        rx_data;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        txn_done;

  logic [7:0]  rd_key = 8'h00;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [11:0] we_addr[$];
  logic [7:0]  we_data[$];
  int re_cnt = 0;
  int done_cnt = 0;
  int sr_low = 0;
  int sr_bad = 0;

  int we_base, re_base, done_base, srl_base, srb_base;

  slave_port #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .master_valid (master_valid),
    .master_ready (master_ready),
    .read_en      (read_en),
    .write_en     (write_en),
    .tx_address   (tx_address),
    .tx_data      (tx_data),
    .tx_burst     (tx_burst),
    .slave_ready  (slave_ready),
    .slave_valid  (slave_valid),
    .rx_data      (rx_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .txn_done     (txn_done)
  );

  always #5 clk = ~clk;

  // Local memory model: one-cycle read latency, data derived from the address.
  always @(posedge clk) begin
    mem_rdata <= mem_re ? (mem_addr[7:0] ^ rd_key) : 8'h00;
  end

  // Event monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      we_addr.push_back(mem_addr);
      we_data.push_back(mem_wdata);
    end
    if (mem_re) re_cnt++;
    if (txn_done) done_cnt++;
    if (!slave_ready) sr_low++;
    if (!slave_ready && !mem_we) sr_bad++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Snapshot monitor counters at a point where the monitor is not updating.
  task automatic mark();
    @(posedge clk);
    #1;
    we_base   = we_addr.size();
    re_base   = re_cnt;
    done_base = done_cnt;
    srl_base  = sr_low;
    srb_base  = sr_bad;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Present one request bit and hold it until the slave will accept it.
  task automatic put_bit(input logic a, input logic d, input logic b);
    int n = 0;
    @(negedge clk);
    master_valid = 1'b1;
    tx_address   = a;
    tx_data      = d;
    tx_burst     = b;
    while (!slave_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_addr(input logic [11:0] a);
    for (int i = 11; i >= 0; i--) put_bit(a[i], 1'b0, 1'b0);
  endtask

  task automatic send_data(input logic [7:0] d, input logic b);
    for (int i = 7; i >= 0; i--) put_bit(1'b0, d[i], (i == 0) ? b : 1'b0);
  endtask

  // Receive one read word; entered at a negedge in the data phase.
  task automatic receive_word(input logic [7:0] exp, input logic b, input int stall_at);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        master_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("rx_hold", rx_data, exp[7-i]);
          check("sv_hold", slave_valid, 1'b1);
        end
      end
      check("rx_bit", rx_data, exp[7-i]);
      check("rx_valid", slave_valid, 1'b1);
      master_ready = 1'b1;
      tx_burst     = (i == 7) ? b : 1'b0;
      @(negedge clk);
    end
    master_ready = 1'b0;
    tx_burst     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, slave_ready, 1'b1);
    check({tag, "_valid"}, slave_valid, 1'b0);
    check({tag, "_rx"},    rx_data,     1'b0);
    check({tag, "_we"},    mem_we,      1'b0);
    check({tag, "_re"},    mem_re,      1'b0);
    check({tag, "_done"},  txn_done,    1'b0);
    check({tag, "_addr"},  mem_addr,    12'h000);
    check({tag, "_wdata"}, mem_wdata,   8'h00);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Single write 0x0A5 <= 0x3C
    mark();
    write_en = 1'b1;
    send_addr(12'h0A5);
    send_data(8'h3C, 1'b0);
    @(negedge clk);
    master_valid = 1'b0;
    write_en     = 1'b0;
    check("wr_we",    mem_we,      1'b1);
    check("wr_addr",  mem_addr,    12'h0A5);
    check("wr_data",  mem_wdata,   8'h3C);
    check("wr_done",  txn_done,    1'b1);
    check("wr_ready", slave_ready, 1'b0);
    @(negedge clk);
    check("wr_we_off",  mem_we,      1'b0);
    check("wr_idle_rdy", slave_ready, 1'b1);
    settle();
    check("wr_we_cnt",   we_addr.size() - we_base, 32'd1);
    check("wr_done_cnt", done_cnt - done_base, 32'd1);

    // Burst write with address wrap: 0xFFF <= 0x11, 0x000 <= 0x22
    mark();
    write_en = 1'b1;
    send_addr(12'hFFF);
    send_data(8'h11, 1'b1);
    send_data(8'h22, 1'b0);
    @(negedge clk);
    master_valid = 1'b0;
    write_en     = 1'b0;
    check("bw_we2",   mem_we,    1'b1);
    check("bw_addr2", mem_addr,  12'h000);
    check("bw_data2", mem_wdata, 8'h22);
    settle();
    check("bw_we_cnt", we_addr.size() - we_base, 32'd2);
    if (we_addr.size() - we_base == 2) begin
      check("bw_q_addr0", we_addr[we_base],     12'hFFF);
      check("bw_q_data0", we_data[we_base],     8'h11);
      check("bw_q_addr1", we_addr[we_base + 1], 12'h000);
      check("bw_q_data1", we_data[we_base + 1], 8'h22);
    end
    check("bw_rdy_low",  sr_low - srl_base, 32'd2);
    check("bw_rdy_bad",  sr_bad - srb_base, 32'd0);
    check("bw_done_cnt", done_cnt - done_base, 32'd2);

    // Read 0x010 (data 0xA6) with master backpressure
    mark();
    rd_key  = 8'hB6;
    read_en = 1'b1;
    send_addr(12'h010);
    @(negedge clk);
    master_valid = 1'b0;
    read_en      = 1'b0;
    check("rd_re",    mem_re,      1'b1);
    check("rd_addr",  mem_addr,    12'h010);
    check("rd_sv1",   slave_valid, 1'b0);
    @(negedge clk);
    check("rd_sv2",   slave_valid, 1'b0);
    check("rd_re_off", mem_re,     1'b0);
    @(negedge clk);
    check("rd_sv3",   slave_valid, 1'b1);
    receive_word(8'hA6, 1'b0, 4);
    check("rd_sv_end",   slave_valid, 1'b0);
    check("rd_done",     txn_done,    1'b1);
    settle();
    check("rd_re_cnt",   re_cnt - re_base, 32'd1);
    check("rd_done_cnt", done_cnt - done_base, 32'd1);
    check("rd_we_cnt",   we_addr.size() - we_base, 32'd0);

    // Read burst with wrap: 0xFFF -> 0xC3, 0x000 -> 0x3C
    mark();
    rd_key  = 8'h3C;
    read_en = 1'b1;
    send_addr(12'hFFF);
    @(negedge clk);
    master_valid = 1'b0;
    read_en      = 1'b0;
    check("rb_re1", mem_re, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rb_sv1", slave_valid, 1'b1);
    receive_word(8'hC3, 1'b1, 8);
    check("rb_gap1",  slave_valid, 1'b0);
    check("rb_re2",   mem_re,      1'b1);
    check("rb_addr2", mem_addr,    12'h000);
    check("rb_done1", txn_done,    1'b1);
    @(negedge clk);
    check("rb_gap2", slave_valid, 1'b0);
    @(negedge clk);
    check("rb_sv2", slave_valid, 1'b1);
    receive_word(8'h3C, 1'b0, 8);
    check("rb_sv_end", slave_valid, 1'b0);
    settle();
    check("rb_re_cnt",   re_cnt - re_base, 32'd2);
    check("rb_done_cnt", done_cnt - done_base, 32'd2);

    // Request stall mid-address, plus opcode change ignored: 0x5A3 <= 0x7E
    mark();
    write_en = 1'b1;
    begin
      logic [11:0] sa;
      sa = 12'h5A3;
      for (int i = 11; i >= 7; i--) put_bit(sa[i], 1'b0, 1'b0);
      repeat (3) begin
        @(negedge clk);
        master_valid = 1'b0;
        tx_address   = 1'b1;
        check("st_ready", slave_ready, 1'b1);
      end
      read_en  = 1'b1;
      write_en = 1'b0;
      for (int i = 6; i >= 0; i--) put_bit(sa[i], 1'b0, 1'b0);
    end
    send_data(8'h7E, 1'b0);
    @(negedge clk);
    master_valid = 1'b0;
    read_en      = 1'b0;
    check("st_we",   mem_we,    1'b1);
    check("st_addr", mem_addr,  12'h5A3);
    check("st_data", mem_wdata, 8'h7E);
    settle();
    check("st_re_cnt", re_cnt - re_base, 32'd0);
    check("st_we_cnt", we_addr.size() - we_base, 32'd1);

    // Illegal requests: both enables, then neither
    mark();
    read_en  = 1'b1;
    write_en = 1'b1;
    repeat (22) begin
      @(negedge clk);
      master_valid = 1'b1;
      tx_address   = 1'b1;
      tx_data      = 1'b1;
    end
    read_en  = 1'b0;
    write_en = 1'b0;
    repeat (22) @(negedge clk);
    master_valid = 1'b0;
    tx_address   = 1'b0;
    tx_data      = 1'b0;
    repeat (3) @(negedge clk);
    check("il_ready", slave_ready, 1'b1);
    settle();
    check("il_we_cnt", we_addr.size() - we_base, 32'd0);
    check("il_re_cnt", re_cnt - re_base, 32'd0);

    // Reset abort after 4 write data bits, then a clean write
    mark();
    write_en = 1'b1;
    send_addr(12'h123);
    for (int i = 7; i >= 4; i--) put_bit(1'b0, (i % 2) == 1, 1'b0);
    @(negedge clk);
    master_valid = 1'b0;
    write_en     = 1'b0;
    rst          = 1'b1;
    #1;
    check_reset_outputs("ab");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("ab_ready", slave_ready, 1'b1);
    settle();
    check("ab_we_cnt", we_addr.size() - we_base, 32'd0);
    mark();
    write_en = 1'b1;
    send_addr(12'h456);
    send_data(8'hC3, 1'b0);
    @(negedge clk);
    master_valid = 1'b0;
    write_en     = 1'b0;
    check("cw_we",   mem_we,    1'b1);
    check("cw_addr", mem_addr,  12'h456);
    check("cw_data", mem_wdata, 8'hC3);
    settle();
    check("cw_we_cnt", we_addr.size() - we_base, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
